mac_rx_monitor: RTL and testbench

Per-channel receive-frame monitor for up to four RGMII MAC ports, all on one clock. It watches each MAC's byte stream and frame-status strobes, then classifies every frame as good, bad, runt or oversize. It keeps saturating statistics counters and sticky error flags per channel and raises one aggregate error pulse. It replaces the single-channel error-detect register and ILA-only visibility in the top level with a readable, clearable statistics block.

---
 rtl/mac_rx_monitor_if.sv | 31 +++
 rtl/mac_rx_monitor.sv | 216 +++++++++++++++++++++
 tb/tb_mac_rx_monitor.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_rx_monitor_if.sv
// Receive byte-stream bundle for up to four MAC channels sharing one clock.
interface mac_rx_monitor_if #(
  parameter int ETHCOUNT = 1
) ();

  logic [8*ETHCOUNT-1:0] mac_rx_data;
  logic [ETHCOUNT-1:0]   mac_rx_valid;
  logic [ETHCOUNT-1:0]   mac_rx_sof;
  logic [ETHCOUNT-1:0]   mac_rx_eof;
  logic [ETHCOUNT-1:0]   mac_rx_fr_good;
  logic [ETHCOUNT-1:0]   mac_rx_fr_err;

  modport master (
    output mac_rx_data,
    output mac_rx_valid,
    output mac_rx_sof,
    output mac_rx_eof,
    output mac_rx_fr_good,
    output mac_rx_fr_err
  );

  modport slave (
    input mac_rx_data,
    input mac_rx_valid,
    input mac_rx_sof,
    input mac_rx_eof,
    input mac_rx_fr_good,
    input mac_rx_fr_err
  );

endinterface

// File: rtl/mac_rx_monitor.sv
// Per-channel receive-frame classifier: good/bad/runt/oversize/byte statistics,
// sticky error flags, an aggregate bad-frame pulse and a registered readout port.
module mac_rx_monitor #(
  parameter int ETHCOUNT = 1,
  parameter int CNT_W    = 32,
  parameter int LEN_W    = 14,
  parameter int MIN_LEN  = 64,
  parameter int MAX_LEN  = 1518
) (
  input  logic                clk,
  input  logic                rst,
  mac_rx_monitor_if.slave     rx,
  input  logic                clear,
  input  logic [1:0]          rd_ch,
  input  logic [2:0]          rd_idx,
  output logic [CNT_W-1:0]    rd_data,
  output logic [ETHCOUNT-1:0] err_sticky,
  output logic [ETHCOUNT-1:0] sync_err,
  output logic                err_det
);

  localparam int IDX_GOOD  = 0;
  localparam int IDX_BAD   = 1;
  localparam int IDX_RUNT  = 2;
  localparam int IDX_OVER  = 3;
  localparam int IDX_BYTES = 4;
  localparam int NCNT      = 5;
  localparam logic [LEN_W-1:0] MIN_L = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

  typedef enum logic [0:0] {IDLE = 1'b0, INFRAME = 1'b1} state_t;

  state_t              state_r     [ETHCOUNT];
  state_t              state_nxt_s [ETHCOUNT];
  logic [LEN_W-1:0]    len_r       [ETHCOUNT];
  logic [LEN_W-1:0]    len_nxt_s   [ETHCOUNT];
  logic [ETHCOUNT-1:0] ferr_r;
  logic [ETHCOUNT-1:0] ferr_nxt_s;
  logic [1:0]          inc_s       [ETHCOUNT][NCNT];
  logic [CNT_W-1:0]    cnt_r       [ETHCOUNT][NCNT];
  logic [ETHCOUNT-1:0] bad_close_s;
  logic [ETHCOUNT-1:0] set_sync_s;
  logic [ETHCOUNT-1:0] err_sticky_r;
  logic [ETHCOUNT-1:0] sync_err_r;
  logic [CNT_W-1:0]    rd_sel_s;
  logic [CNT_W-1:0]    rd_data_r;
  logic                err_det_r;
  logic                data_unused_s;

  // Increment of up to two per cycle (truncation plus a one-byte bad frame)
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] n);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(n);
    if (s[CNT_W]) begin
      sat_add = {CNT_W{1'b1}};
    end else begin
      sat_add = s[CNT_W-1:0];
    end
  endfunction

  assign data_unused_s = ^rx.mac_rx_data;

  // Per-channel next state, frame length, error latch and counter increments
  always_comb begin
    logic             start_v;
    logic             close_v;
    logic [LEN_W-1:0] close_len_v;
    logic             close_ferr_v;
    logic [LEN_W-1:0] len_inc_v;
    logic             bad_v;
    logic             runt_v;
    logic             over_v;
    bad_close_s = {ETHCOUNT{1'b0}};
    set_sync_s  = {ETHCOUNT{1'b0}};
    ferr_nxt_s  = ferr_r;
    for (int c = 0; c < ETHCOUNT; c++) begin
      state_nxt_s[c] = state_r[c];
      len_nxt_s[c]   = len_r[c];
      for (int k = 0; k < NCNT; k++) begin
        inc_s[c][k] = 2'd0;
      end
      start_v      = 1'b0;
      close_v      = 1'b0;
      close_len_v  = len_r[c];
      close_ferr_v = 1'b0;
      len_inc_v    = (len_r[c] == {LEN_W{1'b1}}) ? len_r[c] : len_r[c] + LEN_W'(1);
      case (state_r[c])
        IDLE: begin
          if (rx.mac_rx_valid[c] & rx.mac_rx_sof[c]) begin
            start_v = 1'b1;
          end else if (rx.mac_rx_valid[c]) begin
            set_sync_s[c] = 1'b1;
          end else begin
            start_v = 1'b0;
          end
        end
        INFRAME: begin
          if (rx.mac_rx_valid[c] & rx.mac_rx_sof[c]) begin
            // A new sof truncates the open frame: bad, but no length check
            start_v             = 1'b1;
            inc_s[c][IDX_BAD]   = 2'd1;
            bad_close_s[c]      = 1'b1;
          end else if (rx.mac_rx_valid[c]) begin
            len_nxt_s[c]          = len_inc_v;
            ferr_nxt_s[c]         = ferr_r[c] | rx.mac_rx_fr_err[c];
            inc_s[c][IDX_BYTES]   = 2'd1;
            close_v               = rx.mac_rx_eof[c];
            close_len_v           = len_inc_v;
            close_ferr_v          = ferr_r[c] | rx.mac_rx_fr_err[c];
          end else begin
            ferr_nxt_s[c] = ferr_r[c] | rx.mac_rx_fr_err[c];
          end
        end
        default: begin
          state_nxt_s[c] = IDLE;
        end
      endcase
      if (start_v) begin
        state_nxt_s[c]      = INFRAME;
        len_nxt_s[c]        = LEN_W'(1);
        ferr_nxt_s[c]       = rx.mac_rx_fr_err[c];
        inc_s[c][IDX_BYTES] = 2'd1;
        close_v             = rx.mac_rx_eof[c];
        close_len_v         = LEN_W'(1);
        close_ferr_v        = rx.mac_rx_fr_err[c];
      end else begin
        close_v = close_v;
      end
      bad_v  = ~rx.mac_rx_fr_good[c] | close_ferr_v;
      runt_v = close_len_v < MIN_L;
      over_v = close_len_v > MAX_L;
      if (close_v) begin
        state_nxt_s[c]     = IDLE;
        inc_s[c][IDX_GOOD] = {1'b0, ~(bad_v | runt_v | over_v)};
        inc_s[c][IDX_BAD]  = inc_s[c][IDX_BAD] + {1'b0, bad_v};
        inc_s[c][IDX_RUNT] = {1'b0, runt_v};
        inc_s[c][IDX_OVER] = {1'b0, over_v};
        bad_close_s[c]     = bad_close_s[c] | bad_v;
      end else begin
        state_nxt_s[c] = state_nxt_s[c];
      end
    end
  end

  // Readout select; out-of-range channel or index yields zero
  always_comb begin
    rd_sel_s = {CNT_W{1'b0}};
    for (int c = 0; c < ETHCOUNT; c++) begin
      for (int k = 0; k < NCNT; k++) begin
        if ((rd_ch == 2'(c)) && (rd_idx == 3'(k))) begin
          rd_sel_s = cnt_r[c][k];
        end else begin
          rd_sel_s = rd_sel_s;
        end
      end
    end
  end

  // Channel FSM, length and error-latch registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < ETHCOUNT; c++) begin
        state_r[c] <= IDLE;
        len_r[c]   <= {LEN_W{1'b0}};
      end
      ferr_r <= {ETHCOUNT{1'b0}};
    end else begin
      for (int c = 0; c < ETHCOUNT; c++) begin
        state_r[c] <= state_nxt_s[c];
        len_r[c]   <= len_nxt_s[c];
      end
      ferr_r <= ferr_nxt_s;
    end
  end

  // Statistics, sticky flags and registered outputs; clear beats any increment
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < ETHCOUNT; c++) begin
        for (int k = 0; k < NCNT; k++) begin
          cnt_r[c][k] <= {CNT_W{1'b0}};
        end
      end
      err_sticky_r <= {ETHCOUNT{1'b0}};
      sync_err_r   <= {ETHCOUNT{1'b0}};
      err_det_r    <= 1'b0;
      rd_data_r    <= {CNT_W{1'b0}};
    end else begin
      err_det_r <= |bad_close_s;
      rd_data_r <= rd_sel_s;
      if (clear) begin
        for (int c = 0; c < ETHCOUNT; c++) begin
          for (int k = 0; k < NCNT; k++) begin
            cnt_r[c][k] <= {CNT_W{1'b0}};
          end
        end
        err_sticky_r <= {ETHCOUNT{1'b0}};
        sync_err_r   <= {ETHCOUNT{1'b0}};
      end else begin
        for (int c = 0; c < ETHCOUNT; c++) begin
          for (int k = 0; k < NCNT; k++) begin
            cnt_r[c][k] <= sat_add(cnt_r[c][k], inc_s[c][k]);
          end
        end
        err_sticky_r <= err_sticky_r | bad_close_s;
        sync_err_r   <= sync_err_r | set_sync_s;
      end
    end
  end

  assign rd_data    = rd_data_r;
  assign err_sticky = err_sticky_r;
  assign sync_err   = sync_err_r;
  assign err_det    = err_det_r;

endmodule

// File: tb/tb_mac_rx_monitor.sv
// Scoreboard bench for mac_rx_monitor: an event-level frame model predicts every
// cycle's outputs; a negedge monitor pops and compares them.
module tb_mac_rx_monitor;

  localparam int ETHCOUNT = 2;
  localparam int CNT_W    = 4;
  localparam int LEN_W    = 14;
  localparam int MIN_LEN  = 64;
  localparam int MAX_LEN  = 1518;
  localparam int CMAX     = (1 << CNT_W) - 1;
  localparam int LMAX     = (1 << LEN_W) - 1;

  typedef struct packed {
    logic [CNT_W-1:0]    rd;
    logic                det;
    logic [ETHCOUNT-1:0] sticky;
    logic [ETHCOUNT-1:0] sync;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic                clear;
  logic [1:0]          rd_ch;
  logic [2:0]          rd_idx;
  logic [CNT_W-1:0]    rd_data;
  logic [ETHCOUNT-1:0] err_sticky;
  logic [ETHCOUNT-1:0] sync_err;
  logic                err_det;

  mac_rx_monitor_if #(.ETHCOUNT(ETHCOUNT)) rx ();

  mac_rx_monitor #(
    .ETHCOUNT(ETHCOUNT), .CNT_W(CNT_W), .LEN_W(LEN_W),
    .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)
  ) dut (
    .clk(clk), .rst(rst), .rx(rx), .clear(clear), .rd_ch(rd_ch), .rd_idx(rd_idx),
    .rd_data(rd_data), .err_sticky(err_sticky), .sync_err(sync_err), .err_det(err_det)
  );

  // Reference model state: counters indexed good,bad,runt,oversize,bytes
  int                  m_cnt  [ETHCOUNT][5];
  bit                  m_in   [ETHCOUNT];
  int                  m_len  [ETHCOUNT];
  bit                  m_ferr [ETHCOUNT];
  bit [ETHCOUNT-1:0]   m_sticky;
  bit [ETHCOUNT-1:0]   m_sync;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic void m_reset();
    for (int c = 0; c < ETHCOUNT; c++) begin
      for (int k = 0; k < 5; k++) m_cnt[c][k] = 0;
      m_in[c] = 1'b0; m_len[c] = 0; m_ferr[c] = 1'b0;
    end
    m_sticky = '0; m_sync = '0;
  endfunction

  function automatic void bump(int c, int k);
    if (m_cnt[c][k] < CMAX) m_cnt[c][k] = m_cnt[c][k] + 1;
  endfunction

  function automatic bit m_close(int c, int len, bit bad);
    if (bad) begin bump(c, 1); m_sticky[c] = 1'b1; end
    if (len < MIN_LEN) bump(c, 2);
    if (len > MAX_LEN) bump(c, 3);
    if (!bad && len >= MIN_LEN && len <= MAX_LEN) bump(c, 0);
    m_in[c] = 1'b0;
    return bad;
  endfunction

  function automatic exp_t model_step();
    exp_t e;
    int ch_i, k_i;
    bit v, s, eo, g, fe;
    ch_i = int'(rd_ch);
    k_i  = int'(rd_idx);
    e = '0;
    if (ch_i < ETHCOUNT && k_i < 5) e.rd = CNT_W'(m_cnt[ch_i][k_i]);
    if (rst) begin
      m_reset();
      e.rd = '0;
      return e;
    end
    for (int c = 0; c < ETHCOUNT; c++) begin
      v = rx.mac_rx_valid[c]; s = rx.mac_rx_sof[c]; eo = rx.mac_rx_eof[c];
      g = rx.mac_rx_fr_good[c]; fe = rx.mac_rx_fr_err[c];
      if (v && s) begin
        if (m_in[c]) begin
          bump(c, 1); m_sticky[c] = 1'b1; e.det = 1'b1;
        end
        m_in[c] = 1'b1; m_len[c] = 1; m_ferr[c] = fe;
        bump(c, 4);
        if (eo && m_close(c, 1, !g || m_ferr[c])) e.det = 1'b1;
      end else if (v) begin
        if (m_in[c]) begin
          m_len[c]  = (m_len[c] < LMAX) ? m_len[c] + 1 : LMAX;
          m_ferr[c] = m_ferr[c] | fe;
          bump(c, 4);
          if (eo && m_close(c, m_len[c], !g || m_ferr[c])) e.det = 1'b1;
        end else begin
          m_sync[c] = 1'b1;
        end
      end else if (m_in[c] && fe) begin
        m_ferr[c] = 1'b1;
      end
    end
    if (clear) begin
      for (int c = 0; c < ETHCOUNT; c++)
        for (int k = 0; k < 5; k++) m_cnt[c][k] = 0;
      m_sticky = '0; m_sync = '0;
    end
    e.sticky = m_sticky;
    e.sync   = m_sync;
    return e;
  endfunction

  task automatic tick();
    exp_t e;
    e = model_step();
    @(posedge clk);
    sb_q.push_back(e);
    #1;
  endtask

  task automatic drive_idle();
    rx.mac_rx_valid   = '0;
    rx.mac_rx_sof     = '0;
    rx.mac_rx_eof     = '0;
    rx.mac_rx_fr_err  = '0;
    rx.mac_rx_fr_good = ETHCOUNT'($urandom);
    rx.mac_rx_data    = (8*ETHCOUNT)'($urandom);
    clear             = 1'b0;
  endtask

  task automatic rand_rd();
    rd_ch  = 2'($urandom_range(0, 3));
    rd_idx = 3'($urandom_range(0, 7));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin drive_idle(); rand_rd(); tick(); end
  endtask

  task automatic sweep();
    for (int c = 0; c < 4; c++)
      for (int k = 0; k < 8; k++) begin
        drive_idle(); rd_ch = 2'(c); rd_idx = 3'(k); tick();
      end
  endtask

  task automatic beats(input int ch, input int n, input bit do_sof, input bit do_eof,
                       input bit good, input bit clr_eof, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 7) == 0) begin drive_idle(); rand_rd(); tick(); end
      drive_idle(); rand_rd();
      rx.mac_rx_valid[ch] = 1'b1;
      rx.mac_rx_sof[ch]   = do_sof && (i == 0);
      rx.mac_rx_eof[ch]   = do_eof && (i == n - 1);
      if (do_eof && i == n - 1) rx.mac_rx_fr_good[ch] = good;
      clear = clr_eof && do_eof && (i == n - 1);
      tick();
    end
    drive_idle();
  endtask

  // Monitor: one expected record per clock, compared half a cycle after the edge
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      n_vec++;
      if (rd_data !== mon_e.rd || err_det !== mon_e.det ||
          err_sticky !== mon_e.sticky || sync_err !== mon_e.sync) begin
        n_bad++;
        $display("FAIL outputs @%0t: got rd_data=%0d err_det=%b err_sticky=%b sync_err=%b, want rd_data=%0d err_det=%b err_sticky=%b sync_err=%b",
                 $time, rd_data, err_det, err_sticky, sync_err,
                 mon_e.rd, mon_e.det, mon_e.sticky, mon_e.sync);
      end
    end
  end

  // Watchdog: the run must finish well within this bound
  initial begin
    #2000000;
    $display("FAIL timeout: stimulus did not complete within the wait limit");
    $finish;
  end

  initial begin
    m_reset();
    rst = 1'b1; rd_ch = 2'd0; rd_idx = 3'd0;
    drive_idle();
    repeat (3) tick();
    if (rd_data !== '0 || err_det !== 1'b0 || err_sticky !== '0 || sync_err !== '0) begin
      n_bad++;
      $display("FAIL reset state: rd_data=%0d err_det=%b err_sticky=%b sync_err=%b, want all 0",
               rd_data, err_det, err_sticky, sync_err);
    end
    rst = 1'b0;
    idle(2);

    beats(0, 64, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); idle(3); sweep();
    beats(1, 60, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1); idle(3); sweep();

    beats(0, 1519, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    beats(0, 1518, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    beats(0, 63, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(2); sweep();

    // sof + 10 bytes, then a fresh sof truncates; then a stray byte in IDLE
    beats(0, 11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    beats(0, 70, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    drive_idle(); rand_rd(); rx.mac_rx_valid[0] = 1'b1; tick();
    idle(2); sweep();

    beats(1, 30, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    drive_idle(); rand_rd(); rx.mac_rx_fr_err[1] = 1'b1; tick();
    beats(1, 34, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(2); sweep();

    repeat (3) beats(0, 1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    beats(0, 5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    beats(1, 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(2); sweep();

    drive_idle(); clear = 1'b1; tick(); sweep();

    repeat (20) beats(0, 64, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    sweep();
    beats(0, 64, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    sweep();

    beats(0, 30, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    beats(1, 20, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    drive_idle(); rst = 1'b1; tick(); rst = 1'b0;
    idle(2); sweep();
    beats(0, 64, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); sweep();

    for (int i = 0; i < 64; i++) begin
      drive_idle(); rand_rd();
      rx.mac_rx_valid = 2'b11;
      rx.mac_rx_sof   = (i == 0)  ? 2'b11 : 2'b00;
      rx.mac_rx_eof   = (i == 63) ? 2'b11 : 2'b00;
      if (i == 63) rx.mac_rx_fr_good = 2'b01;
      tick();
    end
    idle(3); sweep();

    for (int n = 0; n < 4000; n++) begin
      drive_idle(); rand_rd();
      for (int c = 0; c < ETHCOUNT; c++) begin
        rx.mac_rx_valid[c]   = ($urandom_range(0, 3) != 0);
        rx.mac_rx_sof[c]     = ($urandom_range(0, 49) == 0);
        rx.mac_rx_eof[c]     = ($urandom_range(0, 49) == 0);
        rx.mac_rx_fr_good[c] = ($urandom_range(0, 5) != 0);
        rx.mac_rx_fr_err[c]  = ($urandom_range(0, 99) == 0);
      end
      clear = ($urandom_range(0, 149) == 0);
      rst   = ($urandom_range(0, 1999) == 0);
      tick();
    end
    rst = 1'b0;
    idle(2); sweep();

    repeat (3) @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    if (n_bad != 0) begin
      $display("FAIL: %0d miscompares", n_bad);
    end else begin
      $display("PASS");
    end
    $finish;
  end

endmodule
